// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC request scheduler.
//   ANG_W_DEF / RES_W_DEF : default angle (Q8.12 deg) and result (Q2.14) widths
//   ANG_P90 / ANG_N90 / ANG_180 : fold thresholds and offset, one bit wider
//                                 than the angle so the add/sub cannot overflow
//   sched_state_t : scheduler FSM states
package cordic_pkg;

  localparam int ANG_W_DEF = 20;
  localparam int RES_W_DEF = 16;

  localparam logic signed [20:0] ANG_P90 = 21'sh05A000;  // +90.0
  localparam logic signed [20:0] ANG_N90 = -ANG_P90;     // -90.0
  localparam logic signed [20:0] ANG_180 = 21'sh0B4000;  // 180.0

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} sched_state_t;

endpackage

// File: rtl/cordic_rr_arb.sv
// cordic_rr_arb: combinational round-robin pick.
//   req_valid [NUM_REQ] : requesters wanting service
//   rr_ptr    [IW]      : highest-priority index this round
//   grant     [NUM_REQ] : one-hot winner (zero when nobody is valid)
//   grant_idx [IW]      : binary index of the winner
//   grant_any           : some requester was granted
module cordic_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);

  // Scan offsets from the far end back towards rr_ptr, so the last hit is
  // the valid index closest to (at or after) rr_ptr.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = IW'(j);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one iterative CORDIC core
// between NUM_REQ angle requesters. Angles outside +/-90 deg are folded by
// 180 deg before launch, and the result is negated (saturating) on return.
//   clk, reset         : clock, synchronous active-high reset
//   req_valid/ready    : per-requester request; ready is a one-hot 1-cycle strobe
//   req_angle          : flattened Q8.12 angles, requester i at [i*ANG_W +: ANG_W]
//   core_start/angle   : launch pulse and folded angle to the core
//   core_done/cos/sin  : core completion pulse and raw result
//   resp_valid/ready   : response handshake
//   resp_id/cos/sin    : originating requester and corrected result
//   resp_err           : watchdog timeout flag
// Build option: define CORDIC_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise resp_err is tied low and WAIT never expires.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ANG_W       = ANG_W_DEF,
  parameter int RES_W       = RES_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ANG_W-1:0]   req_angle,
  output logic                       core_start,
  output logic [ANG_W-1:0]           core_angle,
  input  logic                       core_done,
  input  logic [RES_W-1:0]           core_cos,
  input  logic [RES_W-1:0]           core_sin,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [RES_W-1:0]           resp_cos,
  output logic [RES_W-1:0]           resp_sin,
  output logic                       resp_err
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int AW1 = ANG_W + 1;
  localparam logic signed [AW1-1:0] P90  = AW1'(ANG_P90);
  localparam logic signed [AW1-1:0] N90  = AW1'(ANG_N90);
  localparam logic signed [AW1-1:0] A180 = AW1'(ANG_180);
  localparam logic [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};
  localparam logic [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};

  // Negation with the single unrepresentable case clamped.
  function automatic logic [RES_W-1:0] neg_sat(input logic [RES_W-1:0] v);
    if (v == RES_MIN) return RES_MAX;
    return -v;
  endfunction

  sched_state_t      state;
  logic [IW-1:0]     rr_ptr, cur_id;
  logic              fold_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  cordic_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Fold the granted angle into the core's +/-90 range. One extra bit keeps
  // the +/-180 adjustment exact; the folded value always fits back in ANG_W.
  logic signed [AW1-1:0] ang_ext, ang_fold;
  logic                  fold_c;

  always_comb begin
    ang_ext  = AW1'($signed(req_angle[gnt_idx*ANG_W +: ANG_W]));
    ang_fold = ang_ext;
    fold_c   = 1'b0;
    if (ang_ext > P90) begin
      ang_fold = ang_ext - A180;
      fold_c   = 1'b1;
    end else if (ang_ext < N90) begin
      ang_fold = ang_ext + A180;
      fold_c   = 1'b1;
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;
  assign resp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      fold_q     <= 1'b0;
      req_ready  <= '0;
      core_start <= 1'b0;
      core_angle <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_cos   <= '0;
      resp_sin   <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      req_ready  <= '0;
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            req_ready  <= gnt;
            cur_id     <= gnt_idx;
            core_angle <= ang_fold[ANG_W-1:0];
            fold_q     <= fold_c;
            core_start <= 1'b1;  // visible during LAUNCH
`ifdef CORDIC_SCHED_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_cos   <= fold_q ? neg_sat(core_cos) : core_cos;
            resp_sin   <= fold_q ? neg_sat(core_sin) : core_sin;
            state      <= S_RESP;
          end
`ifdef CORDIC_SCHED_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_cos   <= '0;
            resp_sin   <= '0;
            err_q      <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed + randomized bench for cordic_sched. The core is
// played by the bench; expectations come from a degree-level fold model,
// a saturating-negate model and a round-robin pick over the pending set.
module tb_cordic_sched;

  localparam int NUM_REQ = 4;
  localparam int ANG_W   = 20;
  localparam int RES_W   = 16;
  localparam int TO      = 64;
  localparam int IW      = $clog2(NUM_REQ);
  localparam int DEG     = 4096;  // Q8.12 one degree

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid, req_ready;
  logic [NUM_REQ*ANG_W-1:0] req_angle;
  logic                     core_start, core_done;
  logic [ANG_W-1:0]         core_angle;
  logic [RES_W-1:0]         core_cos, core_sin;
  logic                     resp_valid, resp_ready, resp_err;
  logic [IW-1:0]            resp_id;
  logic [RES_W-1:0]         resp_cos, resp_sin;

  int vectors = 0, miscompares = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  cordic_sched #(.NUM_REQ(NUM_REQ), .ANG_W(ANG_W), .RES_W(RES_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
    .core_start(core_start), .core_angle(core_angle),
    .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_cos(resp_cos), .resp_sin(resp_sin), .resp_err(resp_err)
  );

  // ---- reference model ----
  function automatic bit model_fold(input logic [ANG_W-1:0] a);
    int s;
    s = int'($signed(a));
    return (s > 90 * DEG) || (s < -90 * DEG);
  endfunction

  function automatic logic [ANG_W-1:0] model_core(input logic [ANG_W-1:0] a);
    int s;
    s = int'($signed(a));
    if (s > 90 * DEG) s = s - 180 * DEG;
    else if (s < -90 * DEG) s = s + 180 * DEG;
    return ANG_W'(s);
  endfunction

  function automatic logic [RES_W-1:0] model_res(input logic [RES_W-1:0] v, input bit f);
    int s;
    s = int'($signed(v));
    if (f) s = (s == -32768) ? 32767 : -s;
    return RES_W'(s);
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // ---- helpers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [ANG_W-1:0] a);
    req_angle[r*ANG_W +: ANG_W] = a;
    req_valid[r] = 1'b1;
  endtask

  // One full transaction: grant, launch, core reply (or watchdog), response
  // with optional backpressure. rearm keeps the winner's valid high with a
  // fresh angle after acceptance.
  task automatic txn(input logic [RES_W-1:0] cc, input logic [RES_W-1:0] cs,
                     input int lat, input int bp, input bit rearm, input bit use_done);
    int g, n;
    bit f;
    logic [ANG_W-1:0] a;
    logic [RES_W-1:0] ec, es;
    logic ee;
    g = model_pick(req_valid, exp_ptr);
    n = 0;
    while (req_ready == '0 && n < 50) begin step(); n++; end
    chk("grant_seen", {63'b0, |req_ready}, 64'd1);
    if (g < 0 || req_ready == '0) return;
    a = req_angle[g*ANG_W +: ANG_W];
    f = model_fold(a);
    chk("grant", req_ready, 64'd1 << g);
    chk("core_start", core_start, 64'd1);
    chk("core_angle", core_angle, model_core(a));
    step();
    chk("one_cycle_strobes", {req_ready, core_start}, 64'd0);
    if (rearm) req_angle[g*ANG_W +: ANG_W] = ANG_W'($urandom);
    else req_valid[g] = 1'b0;
    if (use_done) begin
      for (int i = 1; i < lat; i++) begin
        core_cos = RES_W'($urandom);
        core_sin = RES_W'($urandom);
        step();
      end
      core_cos = cc; core_sin = cs; core_done = 1'b1;
      step();
      core_done = 1'b0;
      ec = model_res(cc, f); es = model_res(cs, f); ee = 1'b0;
    end else begin
      n = 0;
      while (!resp_valid && n < 200) begin step(); n++; end
      chk("timeout_cycles", n, TO);
      ec = '0; es = '0; ee = 1'b1;
    end
    chk("resp_valid", resp_valid, 64'd1);
    chk("resp_id", resp_id, g);
    chk("resp_cos", resp_cos, ec);
    chk("resp_sin", resp_sin, es);
    chk("resp_err", resp_err, ee);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("resp_hold", {resp_valid, resp_id, resp_cos, resp_sin, resp_err},
          {1'b1, IW'(g), ec, es, ee});
      chk("no_accept_busy", req_ready, 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_taken", resp_valid, 64'd0);
    exp_ptr = (g + 1) % NUM_REQ;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {req_ready, core_start, core_angle, resp_valid, resp_id, resp_cos, resp_sin, resp_err},
        64'd0);
  endtask

  initial begin
    int r;
    reset = 1'b1; req_valid = '0; req_angle = '0; core_done = 1'b0;
    core_cos = '0; core_sin = '0; resp_ready = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset_state");
    reset = 1'b0;
    step();

    // 30 deg, unfolded
    set_req(0, 20'h1E000);
    txn(16'h376D, 16'h2000, 5, 0, 1'b0, 1'b1);
    // 120 deg folds to -60, result negated
    set_req(2, 20'h78000);
    txn(16'h2000, 16'hC893, 3, 0, 1'b0, 1'b1);
    // exactly +90 is not folded; minimum passes through unchanged
    set_req(1, 20'h5A000);
    txn(16'h8000, 16'h8000, 1, 0, 1'b0, 1'b1);
    // just above +90 folds
    set_req(0, 20'h5A001);
    txn(16'h1234, 16'h8001, 2, 0, 1'b0, 1'b1);
    // exactly -90 is not folded
    set_req(2, 20'hA6000);
    txn(16'h0000, 16'h7FFF, 4, 0, 1'b0, 1'b1);
    // -120 folds to +60; folded minimum saturates
    set_req(3, 20'h88000);
    txn(16'h8000, 16'h1234, 2, 0, 1'b0, 1'b1);

    // fairness: all requesters held valid for 8 transactions
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ANG_W'($urandom));
    for (int i = 0; i < 8; i++)
      txn(RES_W'($urandom), RES_W'($urandom), $urandom_range(6, 1), 0, 1'b1, 1'b1);
    req_valid = '0;
    step();

    // backpressure
    set_req(1, ANG_W'($urandom));
    set_req(2, ANG_W'($urandom));
    txn(RES_W'($urandom), RES_W'($urandom), 3, 10, 1'b0, 1'b1);

    // random traffic
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1) set_req(i, ANG_W'($urandom));
      if (req_valid == '0) begin
        r = $urandom_range(NUM_REQ - 1, 0);
        set_req(r, ANG_W'($urandom));
      end
      txn(RES_W'($urandom), RES_W'($urandom), $urandom_range(8, 1),
          $urandom_range(3, 0), 1'b0, 1'b1);
    end
    req_valid = '0;
    step();

    // reset during WAIT discards the in-flight request
    set_req(1, 20'h32000);
    r = 0;
    while (req_ready == '0 && r < 50) begin step(); r++; end
    chk("rst_grant_seen", req_ready, 64'd2);
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_outputs("reset_mid_wait");
    exp_ptr = 0;
    core_cos = 16'h1111; core_sin = 16'h2222; core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    chk("stale_done_ignored", {resp_valid, core_start, req_ready}, 64'd0);
    set_req(3, 20'h1E000);
    txn(16'h376D, 16'h2000, 2, 0, 1'b0, 1'b1);

`ifdef CORDIC_SCHED_TIMEOUT_EN
    set_req(0, 20'h78000);
    txn('0, '0, 0, 2, 1'b0, 1'b0);
    set_req(1, 20'h1E000);
    txn(16'h376D, 16'h2000, 3, 0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
